// File: rtl/execute_bru_pkg.sv
// Shared types and widths for the branch-unit issue scheduler.
//   bru_uop_t : packed branch micro-op carried from dispatch to the BRU (115 bits)
//   wb_hit()  : writeback-broadcast tag match helper used by the wakeup logic
package execute_bru_pkg;

  localparam int unsigned BRU_UOP_W = 115;
  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned DATA_W    = 32;

  typedef struct packed {
    logic [7:0]           bp_pattern;
    logic                 bp_taken;
    logic                 bp_hit;
    logic [31:0]          bp_target;
    logic [31:0]          pc;
    logic [20:0]          imm;
    logic [7:0]           fid;
    logic [3:0]           bru_cmd;
    logic [3:0]           bagu_cmd;
    logic [ROB_TAG_W-1:0] dst_rob;
  } bru_uop_t;

  // True when a valid writeback broadcast carries the given producer tag.
  function automatic logic wb_hit(input logic                 wb_valid,
                                  input logic [ROB_TAG_W-1:0] wb_rob,
                                  input logic [ROB_TAG_W-1:0] tag);
    return wb_valid && (wb_rob == tag);
  endfunction

endpackage

// File: rtl/execute_bru_iq_entry.sv
// One issue-queue slot: uop payload, two operands (ready bit, producer tag,
// value) and the writeback wakeup/capture for each operand.
//   clk, resetn          : clock, async active-low reset (clears valid/rdy only)
//   i_flush              : drop the entry, ignore wakeup this cycle
//   i_we                 : enqueue into this slot (with same-cycle bypass)
//   i_clr                : slot is being issued, release it
//   i_uop, i_src*        : enqueue payload and operand state
//   i_wb_*               : writeback broadcast
//   o_valid, o_uop,
//   o_src*_rdy/_value    : current slot contents
module execute_bru_iq_entry
  import execute_bru_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_flush,
  input  logic                 i_we,
  input  logic                 i_clr,
  input  bru_uop_t             i_uop,
  input  logic [ROB_TAG_W-1:0] i_src0_rob,
  input  logic [ROB_TAG_W-1:0] i_src1_rob,
  input  logic                 i_src0_rdy,
  input  logic                 i_src1_rdy,
  input  logic [DATA_W-1:0]    i_src0_value,
  input  logic [DATA_W-1:0]    i_src1_value,
  input  logic                 i_wb_valid,
  input  logic [ROB_TAG_W-1:0] i_wb_rob,
  input  logic [DATA_W-1:0]    i_wb_value,
  output logic                 o_valid,
  output bru_uop_t             o_uop,
  output logic                 o_src0_rdy,
  output logic                 o_src1_rdy,
  output logic [DATA_W-1:0]    o_src0_value,
  output logic [DATA_W-1:0]    o_src1_value
);

  logic                 valid_q, valid_d;
  logic [1:0]           rdy_q, rdy_d;
  logic [1:0]           wake;
  logic                 wr_en;
  bru_uop_t             uop_q;
  logic [ROB_TAG_W-1:0] tag_q [2];
  logic [DATA_W-1:0]    val_q [2];

  logic [1:0]           in_rdy;
  logic [ROB_TAG_W-1:0] in_tag [2];
  logic [DATA_W-1:0]    in_val [2];

  assign in_rdy    = {i_src1_rdy, i_src0_rdy};
  assign in_tag[0] = i_src0_rob;
  assign in_tag[1] = i_src1_rob;
  assign in_val[0] = i_src0_value;
  assign in_val[1] = i_src1_value;

  assign wr_en = i_we && !i_flush;

  // Control next-state: flush beats enqueue beats issue-release; wakeup only
  // touches not-ready operands of a live entry.
  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    wake    = '0;
    if (i_flush) begin
      valid_d = 1'b0;
      rdy_d   = '0;
    end else if (i_we) begin
      valid_d = 1'b1;
      for (int k = 0; k < 2; k++) begin
        rdy_d[k] = in_rdy[k] || wb_hit(i_wb_valid, i_wb_rob, in_tag[k]);
      end
    end else begin
      if (i_clr) valid_d = 1'b0;
      for (int k = 0; k < 2; k++) begin
        wake[k] = valid_q && !rdy_q[k] && wb_hit(i_wb_valid, i_wb_rob, tag_q[k]);
        if (wake[k]) rdy_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  // Payload storage is intentionally not reset. A not-ready operand written at
  // enqueue takes i_wb_value, which is correct on a bypass hit and ignored otherwise.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      uop_q <= i_uop;
      for (int k = 0; k < 2; k++) begin
        tag_q[k] <= in_tag[k];
        val_q[k] <= in_rdy[k] ? in_val[k] : i_wb_value;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wake[k]) val_q[k] <= i_wb_value;
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_uop        = uop_q;
  assign o_src0_rdy   = rdy_q[0];
  assign o_src1_rdy   = rdy_q[1];
  assign o_src0_value = val_q[0];
  assign o_src1_value = val_q[1];

endmodule

// File: rtl/execute_bru_issue_sched.sv
// In-order issue queue in front of the branch unit. Circular FIFO of DEPTH
// entries (power of two, 2..16); only the head may issue, and it issues as soon
// as both its operands are ready, with no backpressure from the BRU.
//   clk, resetn          : clock, async active-low reset
//   i_enq_* / o_enq_ready: enqueue handshake from dispatch with operand state
//   i_wb_*               : writeback broadcast used for wakeup
//   i_flush              : discard everything, block issue/enqueue this cycle
//   o_iss_*              : head entry issued this cycle (combinational)
//   o_count              : occupied entries
module execute_bru_issue_sched
  import execute_bru_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_enq_valid,
  output logic                   o_enq_ready,
  input  bru_uop_t               i_enq_uop,
  input  logic [ROB_TAG_W-1:0]   i_enq_src0_rob,
  input  logic [ROB_TAG_W-1:0]   i_enq_src1_rob,
  input  logic                   i_enq_src0_rdy,
  input  logic                   i_enq_src1_rdy,
  input  logic [DATA_W-1:0]      i_enq_src0_value,
  input  logic [DATA_W-1:0]      i_enq_src1_value,
  input  logic                   i_wb_valid,
  input  logic [ROB_TAG_W-1:0]   i_wb_rob,
  input  logic [DATA_W-1:0]      i_wb_value,
  input  logic                   i_flush,
  output logic                   o_iss_valid,
  output bru_uop_t               o_iss_uop,
  output logic [DATA_W-1:0]      o_iss_src0_value,
  output logic [DATA_W-1:0]      o_iss_src1_value,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic enq_fire;
  logic iss_fire;

  logic              ent_valid    [DEPTH];
  bru_uop_t          ent_uop      [DEPTH];
  logic              ent_src0_rdy [DEPTH];
  logic              ent_src1_rdy [DEPTH];
  logic [DATA_W-1:0] ent_src0_val [DEPTH];
  logic [DATA_W-1:0] ent_src1_val [DEPTH];

  // Readiness uses the registered count only; an issue this cycle frees no slot.
  assign o_enq_ready = (count_q < CNT_W'(DEPTH)) && !i_flush;
  assign enq_fire    = i_enq_valid && o_enq_ready;

  assign iss_fire = (count_q != '0) && ent_valid[head_q] &&
                    ent_src0_rdy[head_q] && ent_src1_rdy[head_q] && !i_flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    execute_bru_iq_entry u_entry (
      .clk          (clk),
      .resetn       (resetn),
      .i_flush      (i_flush),
      .i_we         (enq_fire && (tail_q == PTR_W'(g))),
      .i_clr        (iss_fire && (head_q == PTR_W'(g))),
      .i_uop        (i_enq_uop),
      .i_src0_rob   (i_enq_src0_rob),
      .i_src1_rob   (i_enq_src1_rob),
      .i_src0_rdy   (i_enq_src0_rdy),
      .i_src1_rdy   (i_enq_src1_rdy),
      .i_src0_value (i_enq_src0_value),
      .i_src1_value (i_enq_src1_value),
      .i_wb_valid   (i_wb_valid),
      .i_wb_rob     (i_wb_rob),
      .i_wb_value   (i_wb_value),
      .o_valid      (ent_valid[g]),
      .o_uop        (ent_uop[g]),
      .o_src0_rdy   (ent_src0_rdy[g]),
      .o_src1_rdy   (ent_src1_rdy[g]),
      .o_src0_value (ent_src0_val[g]),
      .o_src1_value (ent_src1_val[g])
    );
  end

  // Pointer/count next-state; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (iss_fire) head_d = head_q + PTR_W'(1);
      case ({enq_fire, iss_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_iss_valid      = iss_fire;
  assign o_iss_uop        = ent_uop[head_q];
  assign o_iss_src0_value = ent_src0_val[head_q];
  assign o_iss_src1_value = ent_src1_val[head_q];
  assign o_count          = count_q;

endmodule

// File: tb/tb_execute_bru_issue_sched.sv
// Self-checking bench for execute_bru_issue_sched (DEPTH=4): a scoreboard queue
// holds the expected issue stream; per-scenario tasks check count/ready/valid.
module tb_execute_bru_issue_sched;
  import execute_bru_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 i_enq_valid;
  logic                 o_enq_ready;
  bru_uop_t             i_enq_uop;
  logic [ROB_TAG_W-1:0] i_enq_src0_rob, i_enq_src1_rob;
  logic                 i_enq_src0_rdy, i_enq_src1_rdy;
  logic [DATA_W-1:0]    i_enq_src0_value, i_enq_src1_value;
  logic                 i_wb_valid;
  logic [ROB_TAG_W-1:0] i_wb_rob;
  logic [DATA_W-1:0]    i_wb_value;
  logic                 i_flush;
  logic                 o_iss_valid;
  bru_uop_t             o_iss_uop;
  logic [DATA_W-1:0]    o_iss_src0_value, o_iss_src1_value;
  logic [2:0]           o_count;

  typedef struct {
    bru_uop_t    uop;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  execute_bru_issue_sched #(.DEPTH(4)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_enq_valid      (i_enq_valid),
    .o_enq_ready      (o_enq_ready),
    .i_enq_uop        (i_enq_uop),
    .i_enq_src0_rob   (i_enq_src0_rob),
    .i_enq_src1_rob   (i_enq_src1_rob),
    .i_enq_src0_rdy   (i_enq_src0_rdy),
    .i_enq_src1_rdy   (i_enq_src1_rdy),
    .i_enq_src0_value (i_enq_src0_value),
    .i_enq_src1_value (i_enq_src1_value),
    .i_wb_valid       (i_wb_valid),
    .i_wb_rob         (i_wb_rob),
    .i_wb_value       (i_wb_value),
    .i_flush          (i_flush),
    .o_iss_valid      (o_iss_valid),
    .o_iss_uop        (o_iss_uop),
    .o_iss_src0_value (o_iss_src0_value),
    .o_iss_src1_value (o_iss_src1_value),
    .o_count          (o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  // Scoreboard: every issue seen mid-cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && o_iss_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL iss_unexpected: issued pc=%h, required no issue", o_iss_uop.pc);
      end else begin
        e = sb.pop_front();
        if (o_iss_uop !== e.uop || o_iss_src0_value !== e.v0 || o_iss_src1_value !== e.v1) begin
          n_fail++;
          $display("FAIL iss_payload: got pc=%h v0=%h v1=%h, required pc=%h v0=%h v1=%h",
                   o_iss_uop.pc, o_iss_src0_value, o_iss_src1_value, e.uop.pc, e.v0, e.v1);
        end
      end
    end
  end

  function automatic bru_uop_t mk_uop(input logic [31:0] pc);
    bru_uop_t u;
    u            = '0;
    u.pc         = pc;
    u.bp_target  = pc + 32'h40;
    u.bp_pattern = pc[11:4];
    u.bp_taken   = pc[2];
    u.imm        = {13'd0, pc[7:0]};
    u.fid        = pc[9:2];
    u.bru_cmd    = pc[5:2];
    u.bagu_cmd   = ~pc[5:2];
    u.dst_rob    = pc[6:3];
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_enq_valid = 1'b0;
    i_wb_valid  = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic drive_enq(input logic [31:0] pc,
                           input logic r0, input logic [3:0] t0, input logic [31:0] v0,
                           input logic r1, input logic [3:0] t1, input logic [31:0] v1);
    i_enq_valid      = 1'b1;
    i_enq_uop        = mk_uop(pc);
    i_enq_src0_rdy   = r0;
    i_enq_src0_rob   = t0;
    i_enq_src0_value = v0;
    i_enq_src1_rdy   = r1;
    i_enq_src1_rob   = t1;
    i_enq_src1_value = v1;
  endtask

  task automatic drive_wb(input logic [3:0] rob, input logic [31:0] val);
    i_wb_valid = 1'b1;
    i_wb_rob   = rob;
    i_wb_value = val;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    i_enq_uop = '0;
    {i_enq_src0_rob, i_enq_src1_rob, i_wb_rob} = '0;
    {i_enq_src0_rdy, i_enq_src1_rdy} = '0;
    {i_enq_src0_value, i_enq_src1_value, i_wb_value} = '0;
    #12;
    n_checks++;
    if (o_iss_valid !== 1'b0 || o_enq_ready !== 1'b1 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ready=%b count=%0d, required 0/1/0",
               o_iss_valid, o_enq_ready, o_count);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_enq(32'h1000, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
    sb.push_back('{mk_uop(32'h1000), 32'd5, 32'd5});
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b1 || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_issue: got valid=%b count=%0d, required 1/1", o_iss_valid, o_count);
    end
    tick();
    n_checks++;
    if (o_count !== 3'd0 || o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got count=%0d valid=%b, required 0/0", o_count, o_iss_valid);
    end
  endtask

  task automatic test_wakeup();
    drive_enq(32'h2000, 1'b1, 4'd0, 32'd1, 1'b0, 4'd3, 32'h0);
    sb.push_back('{mk_uop(32'h2000), 32'd1, 32'hDEAD});
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_early1: got valid=%b, required 0", o_iss_valid);
    end
    tick();
    drive_wb(4'd4, 32'hBEEF);
    #1;
    n_checks++;
    if (o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_wrong_tag_cycle: got valid=%b, required 0", o_iss_valid);
    end
    tick();
    drive_wb(4'd3, 32'hDEAD);
    #1;
    n_checks++;
    if (o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_same_cycle: got valid=%b, required 0", o_iss_valid);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_issue: got valid=%b, required 1", o_iss_valid);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_enq(32'h3000, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'd9);
    drive_wb(4'd7, 32'h42);
    sb.push_back('{mk_uop(32'h3000), 32'h42, 32'd9});
    tick();
    idle_inputs();
    drive_wb(4'd7, 32'h99);
    #1;
    n_checks++;
    if (o_iss_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_issue: got valid=%b, required 1", o_iss_valid);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bypass_drain: got count=%0d, required 0", o_count);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        drive_enq(32'h4000, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'h11);
        sb.push_back('{mk_uop(32'h4000), 32'h55, 32'h11});
      end else begin
        a = $urandom;
        b = $urandom;
        drive_enq(32'h4000 + 32'(i * 4), 1'b1, 4'd0, a, 1'b1, 4'd0, b);
        sb.push_back('{mk_uop(32'h4000 + 32'(i * 4)), a, b});
      end
      tick();
    end
    // Full with a blocked head: an extra enqueue must be refused.
    drive_enq(32'hBAD0, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
    #1;
    n_checks++;
    if (o_enq_ready !== 1'b0 || o_count !== 3'd4 || o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got ready=%b count=%0d valid=%b, required 0/4/0",
               o_enq_ready, o_count, o_iss_valid);
    end
    tick();
    idle_inputs();
    drive_wb(4'd5, 32'h55);
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b1 || o_enq_ready !== 1'b0 || o_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_wake: got valid=%b ready=%b count=%0d, required 1/0/4",
               o_iss_valid, o_enq_ready, o_count);
    end
    tick();
    n_checks++;
    if (o_enq_ready !== 1'b1 || o_count !== 3'd3) begin
      n_fail++;
      $display("FAIL full_release: got ready=%b count=%0d, required 1/3", o_enq_ready, o_count);
    end
    // Enqueue and issue every cycle: pointers lap the ring twice.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      drive_enq(32'h5000 + 32'(i * 4), 1'b1, 4'd0, a, 1'b1, 4'd0, b);
      sb.push_back('{mk_uop(32'h5000 + 32'(i * 4)), a, b});
      tick();
    end
    idle_inputs();
    n_checks++;
    if (o_count !== 3'd3) begin
      n_fail++;
      $display("FAIL wrap_steady_count: got count=%0d, required 3", o_count);
    end
    for (int i = 0; i < 20 && o_count !== 3'd0; i++) tick();
    n_checks++;
    if (o_count !== 3'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: got count=%0d pending=%0d, required 0/0", o_count, sb.size());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_enq(32'h6000 + 32'(i * 4), 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h7);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (o_count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_prefill: got count=%0d, required 3", o_count);
    end
    drive_enq(32'h6F00, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
    drive_wb(4'd9, 32'h77);
    i_flush = 1'b1;
    #1;
    n_checks++;
    if (o_iss_valid !== 1'b0 || o_enq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: got valid=%b ready=%b, required 0/0", o_iss_valid, o_enq_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (o_count !== 3'd0 || o_iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got count=%0d valid=%b, required 0/0", o_count, o_iss_valid);
    end
    drive_wb(4'd9, 32'h77);
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (o_iss_valid !== 1'b0 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_stale: got valid=%b count=%0d, required 0/0", o_iss_valid, o_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive_enq(32'h7000 + 32'(i * 4), 1'b1, 4'd0, 32'h3, 1'b0, 4'd2, 32'h0);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (o_count !== 3'd2) begin
      n_fail++;
      $display("FAIL areset_prefill: got count=%0d, required 2", o_count);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (o_iss_valid !== 1'b0 || o_count !== 3'd0 || o_enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b count=%0d ready=%b, required 0/0/1",
               o_iss_valid, o_count, o_enq_ready);
    end
    tick();
    resetn = 1'b1;
    drive_wb(4'd2, 32'h123);
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b0 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_discard: got valid=%b count=%0d, required 0/0", o_iss_valid, o_count);
    end
    drive_enq(32'h8000, 1'b1, 4'd0, 32'hA, 1'b1, 4'd0, 32'hB);
    sb.push_back('{mk_uop(32'h8000), 32'hA, 32'hB});
    tick();
    idle_inputs();
    n_checks++;
    if (o_iss_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_resume: got valid=%b, required 1", o_iss_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_wrap();
    test_flush();
    test_async_reset();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending issues, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
